// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: address width, response encodings and channel FSM states.
package axi_lite_pkg;

  localparam int unsigned ADDR_WIDTH = 32;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_A,
    W_HAVE_D,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

endpackage

// File: rtl/axi_lite_mem_bank.sv
// Word-organised storage with one byte-strobed write port and one registered read port.
// The array itself is never reset; only the read-data register is.
module axi_lite_mem_bank #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]      wdata,
  input  logic [DATA_WIDTH/8-1:0]    wstrb,
  input  logic                       re,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]      rdata
);

  localparam int BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wstrb[b]) begin
          mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  // Non-blocking read gives the pre-write word when read and write hit together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI-Lite memory slave: independent write and read channel FSMs in front of a
// DEPTH x DATA_WIDTH memory bank, with DECERR/SLVERR address checking.
module axi_lite_mem_slave
  import axi_lite_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH      = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic [ADDR_WIDTH-1:0]     AWADDR,
  input  logic                      AWVALID,
  output logic                      AWREADY,
  input  logic [DATA_WIDTH-1:0]     WDATA,
  input  logic [DATA_WIDTH/8-1:0]   WSTRB,
  input  logic                      WVALID,
  output logic                      WREADY,
  output logic [1:0]                BRESP,
  output logic                      BVALID,
  input  logic                      BREADY,
  input  logic [ADDR_WIDTH-1:0]     ARADDR,
  input  logic                      ARVALID,
  output logic                      ARREADY,
  output logic [DATA_WIDTH-1:0]     RDATA,
  output logic [1:0]                RRESP,
  output logic                      RVALID,
  input  logic                      RREADY
);

  localparam int unsigned           BYTES    = DATA_WIDTH / 8;
  localparam int unsigned           LSB      = $clog2(BYTES);
  localparam int unsigned           IDX_W    = $clog2(DEPTH);
  localparam logic [63:0]           SPAN     = 64'(DEPTH) * 64'(BYTES);
  localparam logic [ADDR_WIDTH-1:0] LSB_MASK = ADDR_WIDTH'(BYTES - 1);

  function automatic resp_t decode(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    if (addr < BASE_ADDR || 64'(off) >= SPAN) return RESP_DECERR;
    if ((off & LSB_MASK) != '0) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = (addr - BASE_ADDR) >> LSB;
    return off[IDX_W-1:0];
  endfunction

  // Write channel
  wr_state_t               wr_state;
  logic [ADDR_WIDTH-1:0]   awaddr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;

  logic                    aw_hs, w_hs, commit, mem_we;
  logic [ADDR_WIDTH-1:0]   c_addr;
  logic [DATA_WIDTH-1:0]   c_data;
  logic [DATA_WIDTH/8-1:0] c_strb;
  resp_t                   c_resp;

  // The write commits on whichever handshake completes the address/data pair.
  always_comb begin
    aw_hs  = AWVALID && AWREADY;
    w_hs   = WVALID && WREADY;
    commit = 1'b0;
    c_addr = AWADDR;
    c_data = WDATA;
    c_strb = WSTRB;
    unique case (wr_state)
      W_IDLE:   commit = aw_hs && w_hs;
      W_HAVE_A: begin
        commit = w_hs;
        c_addr = awaddr_q;
      end
      W_HAVE_D: begin
        commit = aw_hs;
        c_data = wdata_q;
        c_strb = wstrb_q;
      end
      default:  commit = 1'b0;
    endcase
    c_resp = decode(c_addr);
    mem_we = commit && (c_resp == RESP_OKAY);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_state <= W_IDLE;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      AWREADY  <= 1'b0;
      WREADY   <= 1'b0;
      BVALID   <= 1'b0;
      BRESP    <= RESP_OKAY;
    end else begin
      unique case (wr_state)
        W_IDLE: begin
          if (commit) begin
            wr_state <= W_RESP;
            AWREADY  <= 1'b0;
            WREADY   <= 1'b0;
            BVALID   <= 1'b1;
            BRESP    <= c_resp;
          end else if (aw_hs) begin
            wr_state <= W_HAVE_A;
            awaddr_q <= AWADDR;
            AWREADY  <= 1'b0;
          end else if (w_hs) begin
            wr_state <= W_HAVE_D;
            wdata_q  <= WDATA;
            wstrb_q  <= WSTRB;
            WREADY   <= 1'b0;
          end else begin
            AWREADY  <= 1'b1;
            WREADY   <= 1'b1;
          end
        end
        W_HAVE_A, W_HAVE_D: begin
          if (commit) begin
            wr_state <= W_RESP;
            AWREADY  <= 1'b0;
            WREADY   <= 1'b0;
            BVALID   <= 1'b1;
            BRESP    <= c_resp;
          end
        end
        W_RESP: begin
          if (BREADY) begin
            wr_state <= W_IDLE;
            BVALID   <= 1'b0;
            AWREADY  <= 1'b1;
            WREADY   <= 1'b1;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // Read channel
  rd_state_t             rd_state;
  logic                  ar_hs, mem_re;
  resp_t                 ar_resp;
  logic [DATA_WIDTH-1:0] bank_rdata;

  always_comb begin
    ar_hs   = ARVALID && ARREADY;
    ar_resp = decode(ARADDR);
    mem_re  = ar_hs && (ar_resp == RESP_OKAY);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rd_state <= R_IDLE;
      ARREADY  <= 1'b0;
      RVALID   <= 1'b0;
      RRESP    <= RESP_OKAY;
    end else begin
      unique case (rd_state)
        R_IDLE: begin
          if (ar_hs) begin
            rd_state <= R_DATA;
            ARREADY  <= 1'b0;
            RVALID   <= 1'b1;
            RRESP    <= ar_resp;
          end else begin
            ARREADY  <= 1'b1;
          end
        end
        R_DATA: begin
          if (RREADY) begin
            rd_state <= R_IDLE;
            RVALID   <= 1'b0;
            ARREADY  <= 1'b1;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  // Error responses return zero data; the bank register only moves on a good read.
  assign RDATA = (RRESP == RESP_OKAY) ? bank_rdata : '0;

  axi_lite_mem_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_bank (
    .clk   (ACLK),
    .rst_n (ARESETN),
    .we    (mem_we),
    .waddr (word_idx(c_addr)),
    .wdata (c_data),
    .wstrb (c_strb),
    .re    (mem_re),
    .raddr (word_idx(ARADDR)),
    .rdata (bank_rdata)
  );

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Randomised bench for axi_lite_mem_slave with a word-array reference model and
// directed scenarios for ordering, strobes, errors, back-pressure, collisions and reset.
module tb_axi_lite_mem_slave;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h1000;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [31:0] AWADDR = '0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY = 1'b0;
  logic [31:0] ARADDR = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY = 1'b0;

  always #5 ACLK = ~ACLK;

  axi_lite_mem_slave #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .BASE_ADDR  (BASE)
  ) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .AWADDR  (AWADDR),
    .AWVALID (AWVALID),
    .AWREADY (AWREADY),
    .WDATA   (WDATA),
    .WSTRB   (WSTRB),
    .WVALID  (WVALID),
    .WREADY  (WREADY),
    .BRESP   (BRESP),
    .BVALID  (BVALID),
    .BREADY  (BREADY),
    .ARADDR  (ARADDR),
    .ARVALID (ARVALID),
    .ARREADY (ARREADY),
    .RDATA   (RDATA),
    .RRESP   (RRESP),
    .RVALID  (RVALID),
    .RREADY  (RREADY)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] ref_mem [DEPTH];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, want 0x%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Response the address rules demand: out of window -> DECERR, unaligned -> SLVERR.
  function automatic logic [1:0] exp_resp(input logic [31:0] a);
    if (a < BASE || a >= BASE + DEPTH * 4) return 2'b11;
    if (a % 4 != 0) return 2'b10;
    return 2'b00;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_awready"}, 32'(AWREADY), 0);
    check_eq({tag, "_wready"},  32'(WREADY),  0);
    check_eq({tag, "_arready"}, 32'(ARREADY), 0);
    check_eq({tag, "_bvalid"},  32'(BVALID),  0);
    check_eq({tag, "_rvalid"},  32'(RVALID),  0);
    check_eq({tag, "_bresp"},   32'(BRESP),   0);
    check_eq({tag, "_rresp"},   32'(RRESP),   0);
    check_eq({tag, "_rdata"},   RDATA,        0);
  endtask

  task automatic write_txn(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input int hold);
    bit aw_done = 0, w_done = 0, hs_aw, hs_w;
    int cyc = 0;
    logic [1:0] r;
    int idx;
    while (!(aw_done && w_done) && cyc < 40) begin
      @(negedge ACLK);
      AWVALID = !aw_done && cyc >= aw_dly;
      AWADDR  = addr;
      WVALID  = !w_done && cyc >= w_dly;
      WDATA   = data;
      WSTRB   = strb;
      hs_aw = AWVALID && AWREADY;
      hs_w  = WVALID && WREADY;
      @(posedge ACLK);
      if (hs_aw) aw_done = 1;
      if (hs_w) w_done = 1;
      cyc++;
    end
    @(negedge ACLK);
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    if (!(aw_done && w_done)) begin
      check_eq("wr_accept_timeout", 0, 1);
      return;
    end
    r = exp_resp(addr);
    check_eq("bvalid_lat", 32'(BVALID), 1);
    check_eq("bresp", 32'(BRESP), 32'(r));
    for (int i = 0; i < hold; i++) begin
      @(negedge ACLK);
      check_eq("bvalid_hold", 32'(BVALID), 1);
      check_eq("bresp_hold", 32'(BRESP), 32'(r));
      check_eq("awready_in_resp", 32'(AWREADY), 0);
      check_eq("wready_in_resp", 32'(WREADY), 0);
    end
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
    check_eq("bvalid_drop", 32'(BVALID), 0);
    if (r == 2'b00) begin
      idx = int'((addr - BASE) / 4);
      for (int b = 0; b < 4; b++) if (strb[b]) ref_mem[idx][b*8 +: 8] = data[b*8 +: 8];
    end
  endtask

  task automatic read_txn(input logic [31:0] addr, input int hold);
    bit hs = 0;
    int cyc = 0;
    logic [1:0] r;
    logic [31:0] expd;
    while (!hs && cyc < 40) begin
      @(negedge ACLK);
      ARVALID = 1'b1;
      ARADDR  = addr;
      hs = ARREADY;
      @(posedge ACLK);
      cyc++;
    end
    @(negedge ACLK);
    ARVALID = 1'b0;
    if (!hs) begin
      check_eq("rd_accept_timeout", 0, 1);
      return;
    end
    r = exp_resp(addr);
    expd = (r == 2'b00) ? ref_mem[int'((addr - BASE) / 4)] : 32'h0;
    check_eq("rvalid_lat", 32'(RVALID), 1);
    check_eq("rresp", 32'(RRESP), 32'(r));
    check_eq("rdata", RDATA, expd);
    for (int i = 0; i < hold; i++) begin
      @(negedge ACLK);
      check_eq("rvalid_hold", 32'(RVALID), 1);
      check_eq("rresp_hold", 32'(RRESP), 32'(r));
      check_eq("rdata_hold", RDATA, expd);
      check_eq("arready_in_data", 32'(ARREADY), 0);
    end
    RREADY = 1'b1;
    @(negedge ACLK);
    RREADY = 1'b0;
    check_eq("rvalid_drop", 32'(RVALID), 0);
  endtask

  initial begin
    logic [31:0] a;

    // Reset state and READY rise on the first edge after release
    repeat (3) @(negedge ACLK);
    check_reset_outputs("rst");
    ARESETN = 1'b1;
    check_eq("awready_pre_edge", 32'(AWREADY), 0);
    @(negedge ACLK);
    check_eq("awready_post_rst", 32'(AWREADY), 1);
    check_eq("wready_post_rst", 32'(WREADY), 1);
    check_eq("arready_post_rst", 32'(ARREADY), 1);

    for (int i = 0; i < int'(DEPTH); i++) begin
      write_txn(BASE + 32'(4 * i), $urandom, 4'hF, $urandom_range(0, 2), $urandom_range(0, 2), 0);
    end

    // AW first, W three cycles later
    write_txn(32'h1008, 32'hDEADBEEF, 4'hF, 0, 3, 0);
    read_txn(32'h1008, 0);
    // W before AW
    write_txn(32'h1004, 32'h11223344, 4'hF, 2, 0, 1);
    write_txn(32'h1004, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
    read_txn(32'h1004, 0);
    check_eq("strobe_merge", ref_mem[1], 32'h11BB33DD);
    write_txn(32'h1000, 32'h55555555, 4'h0, 0, 1, 0);
    read_txn(32'h1000, 0);

    // Error responses
    write_txn(32'h1040, 32'h0BADF00D, 4'hF, 0, 0, 0);
    read_txn(32'h0FFC, 0);
    write_txn(32'h1006, 32'h0BADF00D, 4'hF, 1, 0, 0);
    read_txn(32'h1006, 0);
    read_txn(32'h103C, 0);

    // Back-pressure
    write_txn(32'h1014, 32'h13579BDF, 4'hF, 0, 0, 5);
    read_txn(32'h1014, 5);
    read_txn(32'h2000, 5);

    // Same-cycle commit and read of one word returns the old value
    write_txn(32'h100C, 32'h1, 4'hF, 0, 0, 0);
    @(negedge ACLK);
    check_eq("coll_awready", 32'(AWREADY), 1);
    check_eq("coll_arready", 32'(ARREADY), 1);
    AWVALID = 1'b1; AWADDR = 32'h100C;
    WVALID  = 1'b1; WDATA  = 32'h2; WSTRB = 4'hF;
    ARVALID = 1'b1; ARADDR = 32'h100C;
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    check_eq("coll_bvalid", 32'(BVALID), 1);
    check_eq("coll_rvalid", 32'(RVALID), 1);
    check_eq("coll_rdata_old", RDATA, 32'h1);
    BREADY = 1'b1; RREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0; RREADY = 1'b0;
    ref_mem[3] = 32'h2;
    read_txn(32'h100C, 0);

    // Reset after an AW-only handshake drops the write; memory survives
    @(negedge ACLK);
    check_eq("rst_mid_awready", 32'(AWREADY), 1);
    AWVALID = 1'b1; AWADDR = 32'h1010;
    @(negedge ACLK);
    AWVALID = 1'b0;
    ARESETN = 1'b0;
    WVALID = 1'b1; WDATA = 32'hCAFEF00D; WSTRB = 4'hF;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge ACLK);
    ARESETN = 1'b1;
    WVALID = 1'b0;
    @(negedge ACLK);
    check_eq("rst_mid_awready_back", 32'(AWREADY), 1);
    check_eq("rst_mid_wready_back", 32'(WREADY), 1);
    check_eq("rst_mid_arready_back", 32'(ARREADY), 1);
    for (int i = 0; i < int'(DEPTH); i++) read_txn(BASE + 32'(4 * i), 0);

    // Randomised mix of writes and reads around the window edges
    repeat (80) begin
      a = BASE - 32'd8 + 32'($urandom_range(0, 'h50));
      if ($urandom_range(0, 1) == 0) begin
        write_txn(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 2));
      end else begin
        read_txn(a, $urandom_range(0, 2));
      end
    end
    for (int i = 0; i < int'(DEPTH); i++) read_txn(BASE + 32'(4 * i), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
